// File: rtl/f_alu_arbiter_if.sv
// Bundle for f_alu_arbiter: two requester ports (request + response) and the shared-ALU port.
// The slave modport is the arbiter side; master is the requesters plus the ALU itself.
interface f_alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data1;
  logic [31:0] req0_data2;
  logic [31:0] req0_data3;
  logic [5:0]  req0_select;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data1;
  logic [31:0] req1_data2;
  logic [31:0] req1_data3;
  logic [5:0]  req1_select;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;

  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [31:0] alu_data3;
  logic [5:0]  alu_select;
  logic [31:0] alu_result;
  logic        busy;

  modport slave (
    input  req0_valid, req0_data1, req0_data2, req0_data3, req0_select, rsp0_ready,
    input  req1_valid, req1_data1, req1_data2, req1_data3, req1_select, rsp1_ready,
    input  alu_result,
    output req0_ready, rsp0_valid, rsp0_result,
    output req1_ready, rsp1_valid, rsp1_result,
    output alu_data1, alu_data2, alu_data3, alu_select, busy
  );

  modport master (
    output req0_valid, req0_data1, req0_data2, req0_data3, req0_select, rsp0_ready,
    output req1_valid, req1_data1, req1_data2, req1_data3, req1_select, rsp1_ready,
    output alu_result,
    input  req0_ready, rsp0_valid, rsp0_result,
    input  req1_ready, rsp1_valid, rsp1_result,
    input  alu_data1, alu_data2, alu_data3, alu_select, busy
  );
endinterface

// File: rtl/f_alu_arbiter.sv
// Two-port sequencer sharing one combinational FP ALU; round-robin, or fixed port-0 priority with F_ALU_ARB_FIXED_PRIO_EN.
// Latency: accept -> response valid in LAT+1 cycles (LAT = LONG_LAT for div/sqrt, else SHORT_LAT); one op in flight.
// Backpressure: response held until rsp_ready; requests see ready low outside IDLE and must hold.
module f_alu_arbiter #(
  parameter int          SHORT_LAT = 2,
  parameter int          LONG_LAT  = 8,
  parameter logic [5:0]  SEL_FDIV  = 6'b000011,
  parameter logic [5:0]  SEL_FSQRT = 6'b000100
) (
  input logic           clk,
  input logic           resetn,
  f_alu_arbiter_if.slave bus
);
  localparam int CW = $clog2(LONG_LAT > SHORT_LAT ? LONG_LAT : SHORT_LAT) + 1;
  localparam logic [CW-1:0] SHORT_CNT = CW'(SHORT_LAT - 1);
  localparam logic [CW-1:0] LONG_CNT  = CW'(LONG_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   d1_q, d2_q, d3_q, res_q;
  logic [5:0]    sel_q;
  logic          owner_q;
  logic [CW-1:0] cnt_q;

  logic          grant1;
  logic          accept;
  logic [31:0]   d1_in, d2_in, d3_in;
  logic [5:0]    sel_in;
  logic          long_op;

`ifdef F_ALU_ARB_FIXED_PRIO_EN
  assign grant1 = bus.req1_valid & ~bus.req0_valid;
`else
  logic rr_ptr;
  // rr_ptr high means port 1 is preferred on a tie.
  assign grant1 = bus.req1_valid & (~bus.req0_valid | rr_ptr);
`endif

  assign accept  = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
  assign d1_in   = grant1 ? bus.req1_data1  : bus.req0_data1;
  assign d2_in   = grant1 ? bus.req1_data2  : bus.req0_data2;
  assign d3_in   = grant1 ? bus.req1_data3  : bus.req0_data3;
  assign sel_in  = grant1 ? bus.req1_select : bus.req0_select;
  assign long_op = (sel_in == SEL_FDIV) || (sel_in == SEL_FSQRT);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.rsp0_valid  = 1'b0;
    bus.rsp1_valid  = 1'b0;
    bus.rsp0_result = 32'd0;
    bus.rsp1_result = 32'd0;
    bus.alu_data1   = 32'd0;
    bus.alu_data2   = 32'd0;
    bus.alu_data3   = 32'd0;
    bus.alu_select  = 6'd0;
    bus.busy        = (state != IDLE);
    case (state)
      IDLE: begin
        bus.req0_ready = bus.req0_valid & ~grant1;
        bus.req1_ready = grant1;
        if (accept) state_nx = EXEC;
      end
      EXEC: begin
        bus.alu_data1  = d1_q;
        bus.alu_data2  = d2_q;
        bus.alu_data3  = d3_q;
        bus.alu_select = sel_q;
        if (cnt_q == '0) state_nx = RESP;
      end
      RESP: begin
        if (owner_q) begin
          bus.rsp1_valid  = 1'b1;
          bus.rsp1_result = res_q;
          if (bus.rsp1_ready) state_nx = IDLE;
        end else begin
          bus.rsp0_valid  = 1'b1;
          bus.rsp0_result = res_q;
          if (bus.rsp0_ready) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      d1_q    <= 32'd0;
      d2_q    <= 32'd0;
      d3_q    <= 32'd0;
      sel_q   <= 6'd0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= 32'd0;
`ifndef F_ALU_ARB_FIXED_PRIO_EN
      rr_ptr  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        d1_q    <= d1_in;
        d2_q    <= d2_in;
        d3_q    <= d3_in;
        sel_q   <= sel_in;
        owner_q <= grant1;
        cnt_q   <= long_op ? LONG_CNT : SHORT_CNT;
`ifndef F_ALU_ARB_FIXED_PRIO_EN
        rr_ptr  <= ~grant1;
`endif
      end
      // The ALU is combinational: its output is valid once the counter has expired.
      if (state == EXEC) begin
        if (cnt_q == '0) res_q <= bus.alu_result;
        else             cnt_q <= cnt_q - 1'b1;
      end
    end
  end
endmodule
